bcd_decoder: RTL and testbench

Sequential BCD-to-binary converter for the stopwatch datapath; the inverse of the existing binary-to-BCD encoder. It accepts a three-digit packed BCD value (hundreds, tens, ones) and uses an iterative reverse double-dabble algorithm to produce a 10-bit binary result (0–999). Conversion takes 10 clocks and uses a start/done handshake. The block sits between the digit-entry / preset logic and the binary counters that load a preset time.

---
 rtl/bcd_decoder.sv | 147 ++++++++++++++
 tb/tb_bcd_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_decoder.sv
// bcd_decoder: iterative reverse double-dabble converter.
// Converts a packed 3-digit BCD value to a 10-bit binary value in 10 clocks.
// Handshake: start (accepted only while idle), busy, one-cycle done pulse.
// Optional feature macro: BCD_DIGIT_CHECK_EN. When defined, a start with any
// nibble above 9 is rejected with done+error one clock later. When undefined,
// error is tied low and invalid nibbles run through the normal algorithm.
module bcd_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] BCDIn,
    output logic [9:0]  BinaryOut,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic {StIdle, StConv} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [21:0] work_q, work_d;
    logic [21:0] work_step;
    logic [9:0]  bin_q, bin_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef BCD_DIGIT_CHECK_EN
    logic        err_q, err_d;
    // Rejected start waiting to report done+error on the following edge.
    logic        pend_q, pend_d;
    logic        digit_bad;

    assign digit_bad = (BCDIn[11:8] > 4'd9) || (BCDIn[7:4] > 4'd9) || (BCDIn[3:0] > 4'd9);
`endif

    // One iteration: shift right, then subtract 3 from every BCD nibble >= 8.
    function automatic logic [21:0] iterate(input logic [21:0] w);
        logic [21:0] s;
        s = w >> 1;
        for (int i = 0; i < 3; i++) begin
            if (s[10 + 4 * i + 3]) begin
                s[10 + 4 * i +: 4] = s[10 + 4 * i +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    // Next-state and output logic for the idle/convert controller.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        bin_d     = bin_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        work_step = iterate(work_q);
`ifdef BCD_DIGIT_CHECK_EN
        err_d     = err_q;
        pend_d    = pend_q;
`endif
        case (state_q)
            StIdle: begin
`ifdef BCD_DIGIT_CHECK_EN
                if (pend_q) begin
                    pend_d = 1'b0;
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    bin_d  = '0;
                end else if (start) begin
                    err_d = 1'b0;
                    if (digit_bad) begin
                        pend_d = 1'b1;
                    end else begin
                        state_d = StConv;
                        work_d  = {BCDIn, 10'b0};
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
`else
                if (start) begin
                    state_d = StConv;
                    work_d  = {BCDIn, 10'b0};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
`endif
            end
            StConv: begin
                work_d = work_step;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    bin_d   = work_step[9:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
`ifdef BCD_DIGIT_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any conversion without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= err_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign BinaryOut = bin_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef BCD_DIGIT_CHECK_EN
    assign error     = err_q;
`else
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_decoder.sv
// Testbench for bcd_decoder: directed boundary cases plus random and exhaustive
// valid codes, checked against an arithmetic model (100*h + 10*t + o).
module tb_bcd_decoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] BCDIn;
    logic [9:0]  BinaryOut;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_decoder u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .BCDIn    (BCDIn),
        .BinaryOut(BinaryOut),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_bin(input logic [11:0] bcd);
        return 100 * int'(bcd[11:8]) + 10 * int'(bcd[7:4]) + int'(bcd[3:0]);
    endfunction

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        v[11:8] = 4'($urandom_range(0, 9));
        v[7:4]  = 4'($urandom_range(0, 9));
        v[3:0]  = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Drive a one-cycle start; returns at the negedge after the accepting edge.
    task automatic issue(input logic [11:0] bcd);
        start = 1'b1;
        BCDIn = bcd;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done (bounded); optional stray start pulse at edge glitch_at.
    task automatic wait_done(input int glitch_at, output int edges, output int bc,
                             output int err_seen);
        edges    = 0;
        bc       = 0;
        err_seen = 0;
        while (!done && edges < 20) begin
            if (busy) bc++;
            if (error) err_seen = 1;
            if (edges == glitch_at) begin
                start = 1'b1;
                BCDIn = 12'h999;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        if (error) err_seen = 1;
    endtask

    // Full conversion with value and latency check.
    task automatic convert(input logic [11:0] bcd, input string tag);
        int edges, bc, es;
        @(negedge clk);
        issue(bcd);
        wait_done(-1, edges, bc, es);
        check({tag, " latency"}, edges, 10);
        check({tag, " value"}, int'(BinaryOut), ref_bin(bcd));
    endtask

    initial begin
        int edges, bc, es, dn;
        logic [11:0] v;
        rst   = 1'b1;
        start = 1'b0;
        BCDIn = '0;
        repeat (2) @(negedge clk);
        check("reset BinaryOut", int'(BinaryOut), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset error", int'(error), 0);
        rst = 1'b0;

        // Basic 255 conversion with full timing checks.
        @(negedge clk);
        issue(12'h255);
        check("255 busy after accept", int'(busy), 1);
        wait_done(-1, edges, bc, es);
        check("255 latency", edges, 10);
        check("255 busy cycles", bc, 10);
        check("255 value", int'(BinaryOut), 255);
        check("255 error", int'(error), 0);
        check("255 busy at done", int'(busy), 0);
        @(negedge clk);
        check("255 done drops", int'(done), 0);
        check("255 value held", int'(BinaryOut), 255);

        convert(12'h000, "000");
        convert(12'h999, "999");
        convert(12'h128, "128");

        // Stray start mid-conversion, then back-to-back start on the done cycle.
        @(negedge clk);
        issue(12'h631);
        wait_done(4, edges, bc, es);
        check("glitch latency", edges, 10);
        check("glitch value", int'(BinaryOut), 631);
        issue(12'h047);
        check("b2b busy", int'(busy), 1);
        wait_done(-1, edges, bc, es);
        check("b2b latency", edges, 10);
        check("b2b value", int'(BinaryOut), 47);

        // Reset at iteration 5 of a 999 conversion.
        @(negedge clk);
        issue(12'h999);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst BinaryOut", int'(BinaryOut), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst error", int'(error), 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("midrst no done", dn, 0);
        convert(12'h500, "500");

        // Invalid digit handling.
`ifdef BCD_DIGIT_CHECK_EN
        @(negedge clk);
        issue(12'h1A3);
        check("inv busy E0", int'(busy), 0);
        check("inv done E0", int'(done), 0);
        @(negedge clk);
        check("inv done E1", int'(done), 1);
        check("inv error E1", int'(error), 1);
        check("inv BinaryOut", int'(BinaryOut), 0);
        check("inv busy E1", int'(busy), 0);
        @(negedge clk);
        check("inv done drops", int'(done), 0);
        issue(12'h010);
        wait_done(-1, edges, bc, es);
        check("after inv latency", edges, 10);
        check("after inv value", int'(BinaryOut), 10);
        check("after inv error", int'(error), 0);
`else
        @(negedge clk);
        issue(12'h1A3);
        wait_done(-1, edges, bc, es);
        check("inv latency", edges, 10);
        check("inv error", es, 0);
`endif

        // Random valid codes.
        for (int i = 0; i < 100; i++) begin
            v = rand_bcd();
            convert(v, $sformatf("rand %03h", v));
        end

        // Exhaustive sweep of valid codes.
        for (int h = 0; h < 10; h++) begin
            for (int t = 0; t < 10; t++) begin
                for (int o = 0; o < 10; o++) begin
                    v = {4'(h), 4'(t), 4'(o)};
                    @(negedge clk);
                    issue(v);
                    wait_done(-1, edges, bc, es);
                    check($sformatf("sweep %03h", v), int'(BinaryOut), ref_bin(v));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
